// File: rtl/cg_ptw_pkg.sv
// rtl/cg_ptw_pkg.sv - shared types and constants for the Sv39 page-table walker
package cg_ptw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } ptw_state_e;

  localparam int PTE_V          = 0;
  localparam int PTE_R          = 1;
  localparam int PTE_W          = 2;
  localparam int PTE_X          = 3;
  localparam int PTE_PPN_LSB    = 10;
  localparam int PTE_PPN_MSB    = 53;

  localparam int LEVELS         = 3;
  localparam int VPN_BITS       = 9;
  localparam int PTE_BYTES_LOG2 = 3;
  localparam int ATTR_FAULT_BIT = 10;

  // VPN field indexed at a given walk level (2 = root)
  function automatic logic [VPN_BITS-1:0] vpn_at(input logic [38:0] va, input logic [1:0] lvl);
    case (lvl)
      2'd2:    vpn_at = va[38:30];
      2'd1:    vpn_at = va[29:21];
      default: vpn_at = va[20:12];
    endcase
  endfunction

endpackage

// File: rtl/cg_rr_arbiter.sv
// rtl/cg_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module cg_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  // Scan requesters from the pointer upward; the first asserted one wins
  always_comb begin
    int cand;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cg_ptw_sv39_arbiter.sv
// rtl/cg_ptw_sv39_arbiter.sv - shared Sv39 page-table walker with round-robin TLB front end
module cg_ptw_sv39_arbiter
  import cg_ptw_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int VADDR_WIDTH = 39,
  parameter int PADDR_WIDTH = 56,
  parameter int PPN_WIDTH   = 44,
  parameter int ATTR_WIDTH  = 11,
  parameter int PTE_WIDTH   = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic [PPN_WIDTH-1:0]           i_satp_ppn,
  input  logic [NUM_REQ-1:0]             i_miss,
  input  logic [NUM_REQ*VADDR_WIDTH-1:0] i_miss_vaddr,
  output logic [NUM_REQ-1:0]             o_ptw_valid,
  output logic [PADDR_WIDTH-1:0]         o_ptw_paddr,
  output logic [ATTR_WIDTH-1:0]          o_ptw_pte_attr,
  output logic                           o_mem_req,
  output logic [PADDR_WIDTH-1:0]         o_mem_addr,
  input  logic                           i_mem_ready,
  input  logic                           i_mem_rvalid,
  input  logic [PTE_WIDTH-1:0]           i_mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ptw_state_e               state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         gnt_idx_q;
  logic [NUM_REQ-1:0]       gnt_oh_q;
  logic [NUM_REQ-1:0]       mask_q;
  logic [VADDR_WIDTH-1:0]   va_q;
  logic [1:0]               level_q;

  logic [NUM_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_valid;
  logic [VADDR_WIDTH-1:0]   sel_vaddr;

  logic [PTE_PPN_MSB-PTE_PPN_LSB:0] pte_ppn;
  logic [PTE_PPN_MSB-PTE_PPN_LSB:0] leaf_ppn;
  logic                     pte_invalid;
  logic                     pte_leaf;
  logic                     misaligned;
  logic                     walk_end;
  logic                     walk_fault;
  logic [ATTR_WIDTH-1:0]    attr_nxt;
  logic                     unused_bits;

  cg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (i_miss & ~mask_q),
    .ptr       (rr_ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign sel_vaddr   = i_miss_vaddr[int'(arb_idx)*VADDR_WIDTH +: VADDR_WIDTH];
  assign pte_ppn     = i_mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];
  assign pte_invalid = !i_mem_rdata[PTE_V] || (!i_mem_rdata[PTE_R] && i_mem_rdata[PTE_W]);
  assign pte_leaf    = i_mem_rdata[PTE_R] || i_mem_rdata[PTE_X];
  assign misaligned  = ((level_q == 2'd2) && (|pte_ppn[2*VPN_BITS-1:0])) ||
                       ((level_q == 2'd1) && (|pte_ppn[VPN_BITS-1:0]));
  assign walk_end    = pte_invalid || pte_leaf || (level_q == 2'd0);
  assign walk_fault  = pte_invalid || (pte_leaf && misaligned) || (!pte_leaf && level_q == 2'd0);
  assign unused_bits = ^{i_mem_rdata[PTE_WIDTH-1:PTE_PPN_MSB+1], va_q[11:0]};

  // Superpage leaves take their low PPN bits from the untranslated VPN fields
  always_comb begin
    leaf_ppn = pte_ppn;
    if (level_q == 2'd2) begin
      leaf_ppn[2*VPN_BITS-1:0] = va_q[29:12];
    end else if (level_q == 2'd1) begin
      leaf_ppn[VPN_BITS-1:0] = va_q[20:12];
    end
  end

  // Refill attributes: fault flag above the raw PTE flag bits
  always_comb begin
    attr_nxt                 = '0;
    attr_nxt[9:0]            = i_mem_rdata[9:0];
    attr_nxt[ATTR_FAULT_BIT] = walk_fault;
  end

  // Walk FSM with registered memory request and refill outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      gnt_idx_q      <= '0;
      gnt_oh_q       <= '0;
      mask_q         <= '0;
      va_q           <= '0;
      level_q        <= '0;
      o_ptw_valid    <= '0;
      o_ptw_paddr    <= '0;
      o_ptw_pte_attr <= '0;
      o_mem_req      <= 1'b0;
      o_mem_addr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mask_q <= '0;
          if (arb_valid) begin
            gnt_idx_q  <= arb_idx;
            gnt_oh_q   <= arb_gnt;
            va_q       <= sel_vaddr;
            level_q    <= 2'(LEVELS - 1);
            o_mem_req  <= 1'b1;
            o_mem_addr <= {i_satp_ppn, vpn_at(sel_vaddr, 2'(LEVELS - 1)), {PTE_BYTES_LOG2{1'b0}}};
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            if (walk_end) begin
              o_ptw_valid    <= gnt_oh_q;
              o_ptw_paddr    <= walk_fault ? '0 : {leaf_ppn, 12'b0};
              o_ptw_pte_attr <= attr_nxt;
              state          <= ST_DONE;
            end else begin
              level_q    <= level_q - 2'd1;
              o_mem_req  <= 1'b1;
              o_mem_addr <= {pte_ppn, vpn_at(va_q, level_q - 2'd1), {PTE_BYTES_LOG2{1'b0}}};
              state      <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          o_ptw_valid    <= '0;
          o_ptw_paddr    <= '0;
          o_ptw_pte_attr <= '0;
          rr_ptr         <= (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
          mask_q         <= gnt_oh_q;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cg_ptw_sv39_arbiter.sv
// tb/tb_cg_ptw_sv39_arbiter.sv - directed self-checking bench for the Sv39 walker
module tb_cg_ptw_sv39_arbiter;

  logic         i_clk;
  logic         i_rstn;
  logic [43:0]  i_satp_ppn;
  logic [1:0]   i_miss;
  logic [77:0]  i_miss_vaddr;
  logic [1:0]   o_ptw_valid;
  logic [55:0]  o_ptw_paddr;
  logic [10:0]  o_ptw_pte_attr;
  logic         o_mem_req;
  logic [55:0]  o_mem_addr;
  logic         i_mem_ready;
  logic         i_mem_rvalid;
  logic [63:0]  i_mem_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [38:0] VA0 = 39'h00_4020_3ABC;
  localparam logic [38:0] VAG = 39'h12_3456_7ABC;

  cg_ptw_sv39_arbiter dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_satp_ppn     (i_satp_ppn),
    .i_miss         (i_miss),
    .i_miss_vaddr   (i_miss_vaddr),
    .o_ptw_valid    (o_ptw_valid),
    .o_ptw_paddr    (o_ptw_paddr),
    .o_ptw_pte_attr (o_ptw_pte_attr),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_ready    (i_mem_ready),
    .i_mem_rvalid   (i_mem_rvalid),
    .i_mem_rdata    (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [9:0] fl);
    mk_pte = {10'b0, ppn, fl};
  endfunction

  task automatic chk_refill(input string tag, input logic [1:0] v, input logic [55:0] pa, input logic [10:0] at);
    chk_eq({tag, "_valid"}, 64'(o_ptw_valid), 64'(v));
    chk_eq({tag, "_paddr"}, 64'(o_ptw_paddr), 64'(pa));
    chk_eq({tag, "_attr"},  64'(o_ptw_pte_attr), 64'(at));
  endtask

  // Wait for a request, check its address, optionally stall, then answer with pte
  task automatic mem_access(input logic [63:0] pte, input int stall, input logic [55:0] exp_addr, input string tag);
    int n;
    n = 0;
    while (!o_mem_req && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    chk_eq({tag, "_req"},  64'(o_mem_req), 64'd1);
    chk_eq({tag, "_addr"}, 64'(o_mem_addr), 64'(exp_addr));
    for (int i = 0; i < stall; i++) begin
      @(negedge i_clk);
      chk_eq({tag, "_stall_req"},  64'(o_mem_req), 64'd1);
      chk_eq({tag, "_stall_addr"}, 64'(o_mem_addr), 64'(exp_addr));
    end
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = pte;
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
  endtask

  initial begin
    i_rstn       = 1'b0;
    i_satp_ppn   = 44'h80000;
    i_miss       = 2'b00;
    i_miss_vaddr = '0;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    repeat (2) @(negedge i_clk);
    chk_eq("rst_valid", 64'(o_ptw_valid), 64'd0);
    chk_eq("rst_paddr", 64'(o_ptw_paddr), 64'd0);
    chk_eq("rst_attr",  64'(o_ptw_pte_attr), 64'd0);
    chk_eq("rst_req",   64'(o_mem_req), 64'd0);
    chk_eq("rst_addr",  64'(o_mem_addr), 64'd0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // 4 KiB walk through two pointers, first request stalled 5 cycles
    i_miss_vaddr = {39'h0, VA0};
    i_miss       = 2'b01;
    mem_access(mk_pte(44'h80001, 10'h001), 5, 56'h80000008, "w4k_l2");
    mem_access(mk_pte(44'h80002, 10'h001), 0, 56'h80001008, "w4k_l1");
    mem_access(mk_pte(44'h12345, 10'h0CF), 0, 56'h80002018, "w4k_l0");
    chk_refill("w4k", 2'b01, 56'h12345000, 11'h0CF);
    chk_eq("w4k_req_off", 64'(o_mem_req), 64'd0);
    i_miss = 2'b00;
    @(negedge i_clk);
    chk_eq("w4k_pulse_end", 64'(o_ptw_valid), 64'd0);

    // Stray read data while idle does nothing
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = mk_pte(44'h55555, 10'h0CF);
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    chk_eq("stray_valid", 64'(o_ptw_valid), 64'd0);
    chk_eq("stray_req",   64'(o_mem_req), 64'd0);
    @(negedge i_clk);
    chk_eq("stray_valid2", 64'(o_ptw_valid), 64'd0);

    // Aligned gigapage: one access
    i_miss_vaddr = {39'h0, VAG};
    i_miss       = 2'b01;
    mem_access(mk_pte(44'hC0000, 10'h0CB), 0, 56'h80000240, "giga");
    chk_refill("giga", 2'b01, 56'hF4567000, 11'h0CB);
    i_miss = 2'b00;
    @(negedge i_clk);

    // Misaligned gigapage faults; miss kept high to see the mask gap
    i_miss = 2'b01;
    mem_access(mk_pte(44'hC0001, 10'h0CB), 0, 56'h80000240, "gmis");
    chk_refill("gmis", 2'b01, 56'h0, 11'h4CB);
    @(negedge i_clk);
    chk_eq("mask_gap0", 64'(o_mem_req), 64'd0);
    @(negedge i_clk);
    chk_eq("mask_gap1", 64'(o_mem_req), 64'd0);
    @(negedge i_clk);
    chk_eq("regrant_req",  64'(o_mem_req), 64'd1);
    chk_eq("regrant_addr", 64'(o_mem_addr), 64'h80000240);

    // Reset while waiting for read data, then a late response
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    i_rstn      = 1'b0;
    i_miss      = 2'b00;
    #1;
    chk_eq("mrst_req",   64'(o_mem_req), 64'd0);
    chk_eq("mrst_addr",  64'(o_mem_addr), 64'd0);
    chk_eq("mrst_valid", 64'(o_ptw_valid), 64'd0);
    chk_eq("mrst_paddr", 64'(o_ptw_paddr), 64'd0);
    chk_eq("mrst_attr",  64'(o_ptw_pte_attr), 64'd0);
    @(negedge i_clk);
    i_rstn       = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = mk_pte(44'hC0000, 10'h0CB);
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    chk_eq("late_valid", 64'(o_ptw_valid), 64'd0);
    chk_eq("late_req",   64'(o_mem_req), 64'd0);
    @(negedge i_clk);
    chk_eq("late_valid2", 64'(o_ptw_valid), 64'd0);

    // Invalid PTE at level 1: fault after two accesses
    i_miss_vaddr = {39'h0, VA0};
    i_miss       = 2'b01;
    mem_access(mk_pte(44'h80001, 10'h001), 0, 56'h80000008, "v0_l2");
    mem_access(mk_pte(44'h80002, 10'h0C6), 0, 56'h80001008, "v0_l1");
    chk_refill("v0", 2'b01, 56'h0, 11'h4C6);
    chk_eq("v0_req_off", 64'(o_mem_req), 64'd0);
    i_miss = 2'b00;
    @(negedge i_clk);

    // Pointer at level 0: fault after three accesses
    i_miss = 2'b01;
    mem_access(mk_pte(44'h80001, 10'h001), 0, 56'h80000008, "nl_l2");
    mem_access(mk_pte(44'h80002, 10'h001), 0, 56'h80001008, "nl_l1");
    mem_access(mk_pte(44'h80003, 10'h001), 0, 56'h80002018, "nl_l0");
    chk_refill("nl", 2'b01, 56'h0, 11'h401);
    chk_eq("nl_req_off", 64'(o_mem_req), 64'd0);
    i_miss = 2'b00;
    @(negedge i_clk);

    // Round-robin from pointer 0 with both requesters pending
    i_rstn = 1'b0;
    @(negedge i_clk);
    i_rstn       = 1'b1;
    i_miss_vaddr = {VAG, VA0};
    i_miss       = 2'b11;
    mem_access(mk_pte(44'hC0000, 10'h0CB), 0, 56'h80000008, "rr0");
    chk_refill("rr0", 2'b01, 56'hC0203000, 11'h0CB);
    mem_access(mk_pte(44'hC0000, 10'h0CB), 0, 56'h80000240, "rr1");
    chk_refill("rr1", 2'b10, 56'hF4567000, 11'h0CB);
    mem_access(mk_pte(44'hC0000, 10'h0CB), 0, 56'h80000008, "rr2");
    chk_refill("rr2", 2'b01, 56'hC0203000, 11'h0CB);
    i_miss = 2'b00;
    repeat (2) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
